// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared aluctl codes, state encodings and iteration constants
package alu_exec_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = DATA_W;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_DIV  = 4'b0111;
  localparam logic [3:0] ALU_DIVU = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX} state_t;
  typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_DIVU} md_op_t;

  function automatic logic is_multi(input logic [3:0] code);
    return (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_exec_unit_mul_div_iter.sv
// rtl/alu_exec_unit_mul_div_iter.sv - iterative shift-add multiplier / restoring divider with sign fixup
module mul_div_iter
  import alu_exec_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  md_op_t            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              last,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic [4:0]  cnt_q, cnt_d;
  md_op_t      op_q, op_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign abs_a = a[31] ? -a : a;
  assign abs_b = b[31] ? -b : b;

  // Multiply: acc holds {partial product, remaining multiplier bits}; add on LSB then shift right.
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);

  // Divide: acc holds {remainder, dividend/quotient}; shift left, subtract if it fits.
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = div_shift >= {1'b0, dvs_q};
  assign div_diff  = div_shift[31:0] - dvs_q;

  assign last = (cnt_q == 5'(ITER_COUNT - 1));

  assign prod_fix = qneg_q ? -acc_q : acc_q;
  assign quo_fix  = qneg_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = rneg_q ? -acc_q[63:32] : acc_q[63:32];

  // Next-state for the operand latch and one iteration step.
  always_comb begin
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    a_raw_d = a_raw_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    if (load) begin
      op_d    = op;
      cnt_d   = 5'd0;
      a_raw_d = a;
      dbz_d   = (b == 32'd0);
      if (op == MD_DIVU) begin
        acc_d  = {32'd0, a};
        dvs_d  = b;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
      end else begin
        acc_d  = {32'd0, abs_a};
        dvs_d  = abs_b;
        qneg_d = a[31] ^ b[31];
        rneg_d = a[31];
      end
    end else if (step) begin
      cnt_d = cnt_q + 5'd1;
      if (op_q == MD_MUL) begin
        acc_d = {mul_sum, acc_q[31:1]};
      end else begin
        acc_d = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= 64'd0;
      dvs_q   <= 32'd0;
      a_raw_q <= 32'd0;
      cnt_q   <= 5'd0;
      op_q    <= MD_MUL;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      a_raw_q <= a_raw_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
    end
  end

  // Sign fixup; divide by zero reports all-ones quotient and the raw dividend as remainder.
  always_comb begin
    hi_out = rem_fix;
    lo_out = quo_fix;
    if (op_q == MD_MUL) begin
      hi_out = prod_fix[63:32];
      lo_out = prod_fix[31:0];
    end else if (dbz_q) begin
      hi_out = a_raw_q;
      lo_out = 32'hFFFF_FFFF;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with single-cycle ops and iterative mul/div handshake
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             lt,
  output logic             overflow,
  output logic             div_by_zero
);

  state_t      state_q, state_d;
  logic [31:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic        zero_q, zero_d, lt_q, lt_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic        done_q, done_d, busy_q, busy_d;
  logic        pend_lt_q, pend_lt_d, pend_dbz_q, pend_dbz_d;

  logic        md_load, md_step, md_last;
  md_op_t      md_op;
  logic [31:0] md_hi, md_lo;

  logic [31:0] sum, diff, sc_result;
  logic        sc_zero, sc_lt, sc_ovf, signed_lt;

  assign sum       = a + b;
  assign diff      = a - b;
  assign signed_lt = $signed(a) < $signed(b);

  assign md_op = (aluctl == ALU_MUL) ? MD_MUL : ((aluctl == ALU_DIV) ? MD_DIV : MD_DIVU);

  mul_div_iter u_mul_div_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .step   (md_step),
    .op     (md_op),
    .a      (a),
    .b      (b),
    .last   (md_last),
    .hi_out (md_hi),
    .lo_out (md_lo)
  );

  // Single-cycle datapath: result and flags for logic, arithmetic, compare and shift codes.
  always_comb begin
    sc_result = 32'd0;
    sc_ovf    = 1'b0;
    sc_lt     = signed_lt;
    case (aluctl)
      ALU_AND:  sc_result = a & b;
      ALU_OR:   sc_result = a | b;
      ALU_XOR:  sc_result = a ^ b;
      ALU_NOR:  sc_result = ~(a | b);
      ALU_ADD: begin
        sc_result = sum;
        sc_ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB, ALU_BNE: begin
        sc_result = diff;
        sc_ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_SLTU: sc_result = {31'd0, a < b};
      ALU_SLL:  sc_result = b << shamt;
      ALU_SRL:  sc_result = b >> shamt;
      ALU_SRA:  sc_result = $signed(b) >>> shamt;
      ALU_MUL, ALU_DIV, ALU_DIVU: sc_result = 32'd0;
      default:  sc_lt = 1'b0;
    endcase
    if (aluctl == ALU_BNE) begin
      sc_zero = (a != b);
    end else if (aluctl == 4'b1110 || aluctl == 4'b1111) begin
      sc_zero = 1'b0;
    end else begin
      sc_zero = (sc_result == 32'd0);
    end
  end

  // Handshake FSM and output register next-state.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    zero_d     = zero_q;
    lt_d       = lt_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;
    pend_lt_d  = pend_lt_q;
    pend_dbz_d = pend_dbz_q;
    done_d     = 1'b0;
    md_load    = 1'b0;
    md_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_multi(aluctl)) begin
            md_load    = 1'b1;
            pend_lt_d  = signed_lt;
            pend_dbz_d = (aluctl != ALU_MUL) && (b == 32'd0);
            state_d    = ST_ITER;
          end else begin
            result_d = sc_result;
            zero_d   = sc_zero;
            lt_d     = sc_lt;
            ovf_d    = sc_ovf;
            dbz_d    = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      ST_ITER: begin
        md_step = 1'b1;
        if (md_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = md_lo;
        hi_d     = md_hi;
        lo_d     = md_lo;
        zero_d   = (md_lo == 32'd0);
        lt_d     = pend_lt_q;
        ovf_d    = 1'b0;
        dbz_d    = pend_dbz_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any iteration in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      result_q   <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      zero_q     <= 1'b0;
      lt_q       <= 1'b0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      pend_lt_q  <= 1'b0;
      pend_dbz_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      zero_q     <= zero_d;
      lt_q       <= lt_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      pend_lt_q  <= pend_lt_d;
      pend_dbz_q <= pend_dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign zero        = zero_q;
  assign lt          = lt_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule
